pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer_ras_stack.sv | 48 ++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared next-PC encodings and field widths, also used by the control unit.
package pc_pkg;

  localparam int PC_SRC_W = 3;
  localparam int IMM_W    = 32;
  localparam int JADDR_W  = 26;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SEQ    = 3'b000,
    PC_BRANCH = 3'b001,
    PC_JUMP   = 3'b010,
    PC_JR     = 3'b011,
    PC_CALL   = 3'b100,
    PC_RET    = 3'b101
  } pc_src_e;

  // Register-sourced targets must be word aligned; low bits flag a bad target.
  function automatic logic word_misaligned(input logic [1:0] low);
    return |low;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit (master) and the PC sequencer (slave).
interface pc_sequencer_if import pc_pkg::*; #(
  parameter int ADDR_W = 32
);
  logic                PCWre;
  logic [PC_SRC_W-1:0] PCSrc;
  logic [IMM_W-1:0]    immediate;
  logic [JADDR_W-1:0]  jaddr;
  logic [ADDR_W-1:0]   rs_data;
  logic [ADDR_W-1:0]   Address;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_err;
  logic                misalign;

  modport master (
    output PCWre, PCSrc, immediate, jaddr, rs_data,
    input  Address, ras_empty, ras_full, ras_err, misalign
  );

  modport slave (
    input  PCWre, PCSrc, immediate, jaddr, rs_data,
    output Address, ras_empty, ras_full, ras_err, misalign
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push past full silently drops the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] wptr;
  logic          full;
  logic          empty;

  // ptr names the top entry; the slot after it is the next write, which is
  // also the oldest entry once the stack is full.
  assign wptr  = ptr + PW'(1);
  assign top   = mem[ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= wptr;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Storage carries no reset; a zero count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && Reset) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, return-address stack, sticky error flags.
module pc_sequencer import pc_pkg::*; #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  pc_sequencer_if.slave   bus
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  if (ADDR_W < 28 || ADDR_W > 64) begin : g_bad_addr_w
    $error("pc_sequencer: ADDR_W out of range");
  end
  if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
    $error("pc_sequencer: RESET_VEC not word aligned");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
  end

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] reg_tgt;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] nxt;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              set_err;
  logic              set_mis;
  logic              rs_mis;
  logic              err_q;
  logic              mis_q;

  assign seq     = pc + ADDR_W'(4);
  assign off     = ADDR_W'($signed({bus.immediate, 2'b00}));
  assign br_tgt  = seq + off;
  assign reg_tgt = {bus.rs_data[ADDR_W-1:2], 2'b00};
  assign rs_mis  = word_misaligned(bus.rs_data[1:0]);

  if (ADDR_W > 28) begin : g_jmp_hi
    assign jmp_tgt = {seq[ADDR_W-1:28], bus.jaddr, 2'b00};
  end else begin : g_jmp_lo
    assign jmp_tgt = {bus.jaddr, 2'b00};
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(RAS_DEPTH));

  always_comb begin
    nxt     = seq;
    push    = 1'b0;
    pop     = 1'b0;
    set_err = 1'b0;
    set_mis = 1'b0;
    case (bus.PCSrc)
      PC_BRANCH: nxt = br_tgt;
      PC_JUMP:   nxt = jmp_tgt;
      PC_JR: begin
        nxt     = reg_tgt;
        set_mis = rs_mis;
      end
      PC_CALL: begin
        nxt     = jmp_tgt;
        push    = 1'b1;
        set_err = full;
      end
      PC_RET: begin
        // Underflow falls back to the register target, so it is checked like JR.
        if (empty) begin
          nxt     = reg_tgt;
          set_err = 1'b1;
          set_mis = rs_mis;
        end else begin
          nxt = ras_top;
          pop = 1'b1;
        end
      end
      default: nxt = seq;
    endcase
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .Reset     (Reset),
    .push      (push & bus.PCWre),
    .pop       (pop & bus.PCWre),
    .push_data (seq),
    .top       (ras_top),
    .count     (count)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc    <= RESET_VEC;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (bus.PCWre) begin
      pc <= nxt;
      if (set_err) err_q <= 1'b1;
      if (set_mis) mis_q <= 1'b1;
    end
  end

  assign bus.Address   = pc;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;
  assign bus.misalign  = mis_q;

endmodule
